qam16_mapper: RTL and testbench

QAM16_MAPPER -- requirements
Module: qam16_mapper

---
 rtl/qam16_mapper.sv | 214 +++++++++++++++++++++
 tb/tb_qam16_mapper.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_mapper.sv
// 16-QAM symbol mapper: 4-entry symbol FIFO feeding an SPS-sample, SAMPLE_DIV-spaced I/Q stream.
// First sample SAMPLE_DIV cycles after a pop; no backpressure, writes to a full FIFO are dropped and flagged.
module fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                    ipClk,
  input  logic                    nReset,
  input  logic                    wrVld,
  input  logic [WIDTH-1:0]        wrDat,
  input  logic                    rdPop,
  output logic [WIDTH-1:0]        rdDat,
  output logic                    empty,
  output logic                    wrDrop,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             full;
  logic             wrEn;
  logic             rdEn;

  assign full   = (count == (AW + 1)'(DEPTH));
  assign empty  = (count == '0);
  assign rdEn   = rdPop && !empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign wrEn   = wrVld && (!full || rdEn);
  assign wrDrop = wrVld && !wrEn;
  assign rdDat  = mem[rdPtr];

  always_ff @(posedge ipClk or negedge nReset) begin
    if (!nReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
      case ({wrEn, rdEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ipClk) begin
    if (wrEn) mem[wrPtr] <= wrDat;
  end
endmodule

module qam16_mapper #(
  parameter int SAMPLE_DIV = 4,
  parameter int SPS        = 8,
  parameter int LEVEL      = 32
) (
  input  logic              ipClk,
  input  logic              ipReset,
  input  logic              ipEnable,
  input  logic [3:0]        ipQAMBlock,
  input  logic              ipQAMBlockValid,
  input  logic              ipClearFlags,
  output logic signed [7:0] opI,
  output logic signed [7:0] opQ,
  output logic              opSampleValid,
  output logic              opSymbolStart,
  output logic [2:0]        opDepth,
  output logic              opUnderrun,
  output logic              opOverflow
);
  localparam logic [7:0] DivMax = 8'(SAMPLE_DIV - 1);
  localparam logic [5:0] SpsMax = 6'(SPS - 1);
  localparam logic [7:0] AmpP1  = 8'(LEVEL);
  localparam logic [7:0] AmpP3  = 8'(3 * LEVEL);
  localparam logic [7:0] AmpN1  = 8'(-LEVEL);
  localparam logic [7:0] AmpN3  = 8'(-3 * LEVEL);

  typedef enum logic [1:0] {IDLE, WAIT, RUN} stateT;

  stateT             state;
  stateT             nextState;
  logic [7:0]        prescaler;
  logic [7:0]        nextPrescaler;
  logic [5:0]        sampleCnt;
  logic [5:0]        nextSampleCnt;
  logic [3:0]        curSym;
  logic [3:0]        nextSym;
  logic [3:0]        headSym;
  logic signed [7:0] nextI;
  logic signed [7:0] nextQ;
  logic              nextSampleValid;
  logic              nextSymbolStart;
  logic              pop;
  logic              fifoEmpty;
  logic              underrunSet;
  logic              overflowSet;

  function automatic logic [7:0] grayMap(input logic [1:0] bits);
    case (bits)
      2'b00:   grayMap = AmpN3;
      2'b01:   grayMap = AmpN1;
      2'b11:   grayMap = AmpP1;
      default: grayMap = AmpP3;
    endcase
  endfunction

  fifo #(.WIDTH(4), .DEPTH(4)) symFifo (
    .ipClk  (ipClk),
    .nReset (ipReset),
    .wrVld  (ipQAMBlockValid),
    .wrDat  (ipQAMBlock),
    .rdPop  (pop),
    .rdDat  (headSym),
    .empty  (fifoEmpty),
    .wrDrop (overflowSet),
    .count  (opDepth)
  );

  always_comb begin
    nextState       = state;
    nextPrescaler   = prescaler;
    nextSampleCnt   = sampleCnt;
    nextSym         = curSym;
    nextI           = opI;
    nextQ           = opQ;
    nextSampleValid = 1'b0;
    nextSymbolStart = 1'b0;
    pop             = 1'b0;
    underrunSet     = 1'b0;
    if (!ipEnable) begin
      nextState     = IDLE;
      nextPrescaler = '0;
      nextSampleCnt = '0;
      nextI         = '0;
      nextQ         = '0;
    end else begin
      case (state)
        IDLE: begin
          nextState     = WAIT;
          nextPrescaler = '0;
          nextSampleCnt = '0;
          nextI         = '0;
          nextQ         = '0;
        end
        WAIT: begin
          nextI = '0;
          nextQ = '0;
          if (!fifoEmpty) begin
            pop           = 1'b1;
            nextSym       = headSym;
            nextPrescaler = '0;
            nextSampleCnt = '0;
            nextState     = RUN;
          end
        end
        RUN: begin
          if (prescaler == DivMax) begin
            nextPrescaler   = '0;
            nextSampleValid = 1'b1;
            nextSymbolStart = (sampleCnt == '0);
            nextI           = grayMap(curSym[3:2]);
            nextQ           = grayMap(curSym[1:0]);
            // Last sample of the symbol: chain the next one with no gap, or fall back to WAIT.
            if (sampleCnt == SpsMax) begin
              nextSampleCnt = '0;
              if (!fifoEmpty) begin
                pop     = 1'b1;
                nextSym = headSym;
              end else begin
                underrunSet = 1'b1;
                nextState   = WAIT;
              end
            end else begin
              nextSampleCnt = sampleCnt + 1'b1;
            end
          end else begin
            nextPrescaler = prescaler + 1'b1;
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state         <= IDLE;
      prescaler     <= '0;
      sampleCnt     <= '0;
      curSym        <= '0;
      opI           <= '0;
      opQ           <= '0;
      opSampleValid <= 1'b0;
      opSymbolStart <= 1'b0;
      opUnderrun    <= 1'b0;
      opOverflow    <= 1'b0;
    end else begin
      state         <= nextState;
      prescaler     <= nextPrescaler;
      sampleCnt     <= nextSampleCnt;
      curSym        <= nextSym;
      opI           <= nextI;
      opQ           <= nextQ;
      opSampleValid <= nextSampleValid;
      opSymbolStart <= nextSymbolStart;
      // A set event in the same cycle as a clear wins.
      opUnderrun    <= underrunSet | (opUnderrun & ~ipClearFlags);
      opOverflow    <= overflowSet | (opOverflow & ~ipClearFlags);
    end
  end
endmodule

// File: tb/tb_qam16_mapper.sv
// Self-checking bench for qam16_mapper: directed scenarios plus a randomized run against a queue-based model.
module tb_qam16_mapper;
  localparam int SAMPLE_DIV = 4;
  localparam int SPS        = 8;
  localparam int LEVEL      = 32;

  logic              ipClk = 1'b0;
  logic              ipReset = 1'b1;
  logic              ipEnable = 1'b0;
  logic [3:0]        ipQAMBlock = 4'h0;
  logic              ipQAMBlockValid = 1'b0;
  logic              ipClearFlags = 1'b0;
  logic signed [7:0] opI;
  logic signed [7:0] opQ;
  logic              opSampleValid;
  logic              opSymbolStart;
  logic [2:0]        opDepth;
  logic              opUnderrun;
  logic              opOverflow;

  int errors = 0;
  int checks = 0;

  // Reference model state: symbol queue, mode (0 idle, 1 wait, 2 run), countdown to next sample.
  logic [3:0]        mQ[$];
  int                mMode;
  logic [3:0]        mCur;
  int                mRemain;
  int                mIdx;
  logic signed [7:0] eI;
  logic signed [7:0] eQ;
  logic              eVld;
  logic              eStart;
  logic              eUnd;
  logic              eOvf;

  always #5 ipClk = ~ipClk;

  qam16_mapper #(.SAMPLE_DIV(SAMPLE_DIV), .SPS(SPS), .LEVEL(LEVEL)) dut (
    .ipClk           (ipClk),
    .ipReset         (ipReset),
    .ipEnable        (ipEnable),
    .ipQAMBlock      (ipQAMBlock),
    .ipQAMBlockValid (ipQAMBlockValid),
    .ipClearFlags    (ipClearFlags),
    .opI             (opI),
    .opQ             (opQ),
    .opSampleValid   (opSampleValid),
    .opSymbolStart   (opSymbolStart),
    .opDepth         (opDepth),
    .opUnderrun      (opUnderrun),
    .opOverflow      (opOverflow)
  );

  // Gray code position along the constellation axis, then amplitude (2p-3)*LEVEL.
  function automatic logic signed [7:0] amp(input logic [1:0] b);
    int p;
    p = 2 * int'(b[1]) + int'(b[1] ^ b[0]);
    return 8'((2 * p - 3) * LEVEL);
  endfunction

  task automatic modelReset();
    mQ.delete();
    mMode = 0; mCur = 4'h0; mRemain = 0; mIdx = 0;
    eI = '0; eQ = '0; eVld = 1'b0; eStart = 1'b0; eUnd = 1'b0; eOvf = 1'b0;
  endtask

  task automatic modelEdge();
    logic popNow, undSet, ovfSet;
    logic [3:0] head;
    popNow = 1'b0; undSet = 1'b0; ovfSet = 1'b0;
    eVld = 1'b0; eStart = 1'b0;
    head = (mQ.size() > 0) ? mQ[0] : 4'h0;
    if (!ipEnable) begin
      mMode = 0; eI = '0; eQ = '0;
    end else if (mMode == 0) begin
      mMode = 1; eI = '0; eQ = '0;
    end else if (mMode == 1) begin
      eI = '0; eQ = '0;
      if (mQ.size() > 0) begin
        popNow = 1'b1; mCur = head; mRemain = SAMPLE_DIV; mIdx = 0; mMode = 2;
      end
    end else begin
      mRemain--;
      if (mRemain == 0) begin
        eVld = 1'b1; eStart = (mIdx == 0);
        eI = amp(mCur[3:2]); eQ = amp(mCur[1:0]);
        mRemain = SAMPLE_DIV;
        if (mIdx == SPS - 1) begin
          mIdx = 0;
          if (mQ.size() > 0) begin popNow = 1'b1; mCur = head; end
          else begin undSet = 1'b1; mMode = 1; end
        end else begin
          mIdx++;
        end
      end
    end
    if (popNow) void'(mQ.pop_front());
    if (ipQAMBlockValid) begin
      if (mQ.size() < 4) mQ.push_back(ipQAMBlock);
      else ovfSet = 1'b1;
    end
    eUnd = undSet || (eUnd && !ipClearFlags);
    eOvf = ovfSet || (eOvf && !ipClearFlags);
  endtask

  task automatic cyc(input logic en, input logic vld, input logic [3:0] sym, input logic clr);
    ipEnable = en; ipQAMBlockValid = vld; ipQAMBlock = sym; ipClearFlags = clr;
    @(posedge ipClk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    ipEnable = 1'b0; ipQAMBlockValid = 1'b0; ipClearFlags = 1'b0;
    #2 ipReset = 1'b0;
    modelReset();
    @(posedge ipClk);
    #1 ipReset = 1'b1;
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    #1 ipReset = 1'b0;
    modelReset();
    ipEnable = 1'b1; ipQAMBlockValid = 1'b1; ipQAMBlock = 4'h9;
    @(posedge ipClk);
    #1;
    obs = {opI, opQ, opSampleValid, opSymbolStart, opDepth, opUnderrun, opOverflow};
    checks++;
    if (obs !== 23'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    ipReset = 1'b1;
    cyc(1'b1, 1'b1, 4'h6, 1'b0);
    checks++;
    if (opDepth !== 3'd1) begin
      errors++; $display("FAIL reset_first_write: depth %0d expected 1", opDepth);
    end
  endtask

  task automatic test_single();
    int nStrobe, nStart, lastT, firstT;
    doReset();
    nStrobe = 0; nStart = 0; lastT = -1; firstT = -1;
    cyc(1'b1, 1'b1, 4'b1001, 1'b0);
    for (int t = 0; t < 40; t++) begin
      cyc(1'b1, 1'b0, 4'h0, 1'b0);
      if (opSampleValid) begin
        checks++;
        if (opI !== 8'sd96 || opQ !== -8'sd32) begin
          errors++; $display("FAIL single_value: got (%0d,%0d) expected (96,-32)", opI, opQ);
        end
        if (lastT >= 0) begin
          checks++;
          if (t - lastT != SAMPLE_DIV) begin
            errors++; $display("FAIL single_spacing: got %0d expected %0d", t - lastT, SAMPLE_DIV);
          end
        end else begin
          firstT = t;
        end
        if (opSymbolStart) nStart++;
        nStrobe++; lastT = t;
      end
    end
    checks++;
    if (firstT != SAMPLE_DIV) begin
      errors++; $display("FAIL single_latency: got %0d expected %0d", firstT, SAMPLE_DIV);
    end
    checks++;
    if (nStrobe != SPS) begin
      errors++; $display("FAIL single_count: got %0d expected %0d", nStrobe, SPS);
    end
    checks++;
    if (nStart != 1) begin
      errors++; $display("FAIL single_start: got %0d expected 1", nStart);
    end
    checks++;
    if (opUnderrun !== 1'b1 || opI !== 8'sd0 || opQ !== 8'sd0) begin
      errors++; $display("FAIL single_underrun: und %b I %0d Q %0d expected 1,0,0", opUnderrun, opI, opQ);
    end
  endtask

  task automatic test_back_to_back();
    int n, lastT, peak;
    logic signed [7:0] expA;
    doReset();
    n = 0; lastT = -1; peak = 0;
    for (int t = 0; t < 130; t++) begin
      case (t)
        0:       cyc(1'b1, 1'b1, 4'b0000, 1'b0);
        1:       cyc(1'b1, 1'b1, 4'b1111, 1'b0);
        2:       cyc(1'b1, 1'b1, 4'b1010, 1'b0);
        default: cyc(1'b1, 1'b0, 4'h0, 1'b0);
      endcase
      if (int'(opDepth) > peak) peak = int'(opDepth);
      if (opSampleValid) begin
        if (n < 8) expA = -8'sd96;
        else if (n < 16) expA = 8'sd32;
        else expA = 8'sd96;
        checks++;
        if (opI !== expA || opQ !== expA) begin
          errors++; $display("FAIL b2b_value[%0d]: got (%0d,%0d) expected (%0d,%0d)", n, opI, opQ, expA, expA);
        end
        if (lastT >= 0) begin
          checks++;
          if (t - lastT != SAMPLE_DIV) begin
            errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", n, t - lastT, SAMPLE_DIV);
          end
        end
        lastT = t; n++;
      end
    end
    checks++;
    if (n != 3 * SPS) begin
      errors++; $display("FAIL b2b_count: got %0d expected %0d", n, 3 * SPS);
    end
    checks++;
    if (peak != 2) begin
      errors++; $display("FAIL b2b_peak_depth: got %0d expected 2", peak);
    end
  endtask

  task automatic test_overflow();
    doReset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 4'(i), 1'b0);
      if (i == 3) begin
        checks++;
        if (opOverflow !== 1'b0) begin
          errors++; $display("FAIL ovf_early: got %b expected 0", opOverflow);
        end
      end
    end
    checks++;
    if (opDepth !== 3'd4 || opOverflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set: depth %0d ovf %b expected 4,1", opDepth, opOverflow);
    end
    cyc(1'b0, 1'b0, 4'h0, 1'b1);
    checks++;
    if (opDepth !== 3'd4 || opOverflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: depth %0d ovf %b expected 4,0", opDepth, opOverflow);
    end
    cyc(1'b0, 1'b1, 4'h7, 1'b1);
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    checks++;
    if (opOverflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set_priority: got %b expected 1", opOverflow);
    end
  endtask

  task automatic test_full_pop();
    doReset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 4'(i), 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 1'b0);
    checks++;
    if (opDepth !== 3'd3) begin
      errors++; $display("FAIL full_pop_first: depth %0d expected 3", opDepth);
    end
    cyc(1'b1, 1'b1, 4'h4, 1'b0);
    repeat (SAMPLE_DIV * SPS - 2) cyc(1'b1, 1'b0, 4'h0, 1'b0);
    checks++;
    if (opDepth !== 3'd4 || opSampleValid !== 1'b0) begin
      errors++; $display("FAIL full_pop_before: depth %0d vld %b expected 4,0", opDepth, opSampleValid);
    end
    cyc(1'b1, 1'b1, 4'h5, 1'b0);
    checks++;
    if (opSampleValid !== 1'b1 || opDepth !== 3'd4 || opOverflow !== 1'b0 || opI !== -8'sd96 || opQ !== -8'sd96) begin
      errors++; $display("FAIL full_pop_coincident: vld %b depth %0d ovf %b I %0d Q %0d expected 1,4,0,-96,-96",
                         opSampleValid, opDepth, opOverflow, opI, opQ);
    end
    repeat (SAMPLE_DIV) cyc(1'b1, 1'b0, 4'h0, 1'b0);
    checks++;
    if (opSampleValid !== 1'b1 || opSymbolStart !== 1'b1 || opI !== -8'sd96 || opQ !== -8'sd32) begin
      errors++; $display("FAIL full_pop_next_symbol: vld %b start %b I %0d Q %0d expected 1,1,-96,-32",
                         opSampleValid, opSymbolStart, opI, opQ);
    end
  endtask

  task automatic test_enable_drop();
    int n, firstT;
    doReset();
    cyc(1'b1, 1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 1'b1, 4'b1111, 1'b0);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      cyc(1'b1, 1'b0, 4'h0, 1'b0);
      if (opSampleValid) n++;
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL en_drop_reach_s3: got %0d strobes expected 4", n);
    end
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    checks++;
    if (opI !== 8'sd0 || opQ !== 8'sd0 || opSampleValid !== 1'b0) begin
      errors++; $display("FAIL en_drop_zero: I %0d Q %0d vld %b expected 0,0,0", opI, opQ, opSampleValid);
    end
    n = 0;
    repeat (10) begin
      cyc(1'b0, 1'b0, 4'h0, 1'b0);
      if (opSampleValid) n++;
    end
    checks++;
    if (n != 0 || opDepth !== 3'd1) begin
      errors++; $display("FAIL en_drop_idle: strobes %0d depth %0d expected 0,1", n, opDepth);
    end
    firstT = -1;
    for (int i = 0; i < 20 && firstT < 0; i++) begin
      cyc(1'b1, 1'b0, 4'h0, 1'b0);
      if (opSampleValid) begin
        firstT = i;
        checks++;
        if (opSymbolStart !== 1'b1 || opI !== 8'sd32 || opQ !== 8'sd32) begin
          errors++; $display("FAIL en_restart_value: start %b I %0d Q %0d expected 1,32,32", opSymbolStart, opI, opQ);
        end
      end
    end
    checks++;
    if (firstT != SAMPLE_DIV + 1) begin
      errors++; $display("FAIL en_restart_latency: got %0d expected %0d", firstT, SAMPLE_DIV + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] obs;
    int n;
    doReset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 4'(i), 1'b0);
    repeat (4) cyc(1'b1, 1'b0, 4'h0, 1'b0);
    checks++;
    if (opDepth !== 3'd3) begin
      errors++; $display("FAIL reset_mid_setup: depth %0d expected 3", opDepth);
    end
    #2 ipReset = 1'b0;
    modelReset();
    #1;
    obs = {opI, opQ, opSampleValid, opSymbolStart, opDepth, opUnderrun, opOverflow};
    checks++;
    if (obs !== 23'h0) begin
      errors++; $display("FAIL reset_mid_async: got %h expected 0", obs);
    end
    @(posedge ipClk);
    #1 ipReset = 1'b1;
    n = 0;
    repeat (40) begin
      cyc(1'b1, 1'b0, 4'h0, 1'b0);
      if (opSampleValid) n++;
    end
    checks++;
    if (n != 0 || opDepth !== 3'd0) begin
      errors++; $display("FAIL reset_mid_quiet: strobes %0d depth %0d expected 0,0", n, opDepth);
    end
    cyc(1'b1, 1'b1, 4'b1101, 1'b0);
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      cyc(1'b1, 1'b0, 4'h0, 1'b0);
      if (opSampleValid) n++;
    end
    checks++;
    if (n != 1 || opI !== 8'sd32 || opQ !== -8'sd32) begin
      errors++; $display("FAIL reset_mid_new_write: strobes %0d I %0d Q %0d expected 1,32,-32", n, opI, opQ);
    end
  endtask

  task automatic test_random();
    logic [22:0] obs, exp;
    int vldPct [4];
    vldPct[0] = 3; vldPct[1] = 30; vldPct[2] = 1; vldPct[3] = 10;
    doReset();
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 800; c++) begin
        cyc($urandom_range(0, 19) != 0,
            $urandom_range(0, 99) < vldPct[ph],
            4'($urandom),
            $urandom_range(0, 29) == 0);
        obs = {opI, opQ, opSampleValid, opSymbolStart, opDepth, opUnderrun, opOverflow};
        exp = {eI, eQ, eVld, eStart, 3'(mQ.size()), eUnd, eOvf};
        checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL random[%0d.%0d]: got %h expected %h", ph, c, obs, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
